argmax_reduction_pipe: RTL and testbench
========================================

Name: argmax_reduction_pipe

Overview:
- Parametrised, fully pipelined argmax over one spectrum frame of SIZE magnitude bins.
- Returns the largest magnitude and its bin index.
- Successor to the single-stage pair comparator in the find_maximas path.
- Generalised in bin count and data width, with runtime band limits, deterministic tie-break, a valid/ready handshake with backpressure, and one frame accepted per cycle.

Parameters:
SIZE, 512, number of bins per frame; power of two, >= 2
DATA_W, 16, magnitude width in bits
LEVELS, $clog2(SIZE), derived, comparator tree depth; not overridable
IDX_W, $clog2(SIZE), derived, bin index width

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
in_mag  in  DATA_W x SIZE  unpacked array of bin magnitudes, element k = bin k
in_valid  in  1  frame present on in_mag
in_ready  out  1  block can accept a frame this cycle
band_lo  in  IDX_W  lowest bin included in the search, sampled on accept
band_hi  in  IDX_W  highest bin included in the search, sampled on accept
out_max  out  DATA_W  maximum magnitude of the frame
out_index  out  IDX_W  bin index of out_max
out_none  out  1  every included bin was zero, or the band was empty
out_valid  out  1  result present
out_ready  in  1  consumer accepts the result

Behaviour:
- Reset values: out_valid=0, out_max=0, out_index=0, out_none=0, all internal stage valids=0. in_ready comes out of reset as 1. Data registers need no reset.
- Accept: a frame is accepted on a rising edge where in_valid && in_ready.
- Stall: stall = out_valid && !out_ready, and in_ready = !stall.
  - While stalled, every pipeline register and valid bit holds its value.
  - While not stalled, the whole pipe advances one stage per cycle, bubbles included.
- Stage 0 (capture):
  - Each bin k is registered as a {mag, idx} pair.
  - mag is forced to 0 when k < band_lo or k > band_hi; idx = k, IDX_W bits.
  - band_lo > band_hi means an empty band: every bin is masked.
- Stages 1..LEVELS (comparator tree):
  - Each stage halves the candidate count and is registered.
  - Pairing is adjacent: stage s compares element 2m against element 2m+1.
  - Winner: the larger mag. On equal mag, the lower idx wins.
  - Consequence: the result is the lowest-indexed bin among the maxima.
- Output:
  - out_max and out_index are the final stage pair.
  - out_none = (out_max == 0), registered together with the final stage.
  - When out_none=1, out_index is the lowest masked or zero bin, normally 0. Consumers ignore out_index when out_none=1.
- Latency: LEVELS+1 cycles from the accept edge to out_valid=1, absent stalls. Latency is 10 for SIZE=512.
- Throughput: one frame per cycle while out_ready=1. Frames leave in order; none are dropped or duplicated.
- Widths:
  - Comparison is unsigned on DATA_W bits.
  - Index is carried separately; it is not packed above the magnitude, so it cannot bias the compare.
- Boundary conditions:
  - SIZE=2 gives LEVELS=1 and latency 2.
  - band_lo = band_hi = k: the result is bin k, or none if its magnitude is 0.
  - Simultaneous accept and output handshake in the same cycle are both honoured.
  - in_valid=0 inserts a bubble.
- Reset mid-operation: asserting reset_n low flushes every in-flight frame immediately (asynchronously). out_valid drops without waiting for the clock. No partial result appears after release.
- After reset release, the first accept can occur on the first rising edge.

Optional Feature:
- Macro: ARGMAX_THRESHOLD_EN.
- With the macro defined:
  - Adds input port threshold [DATA_W-1:0], sampled on accept and carried down the pipe with its frame.
  - Adds output port out_peak, 1 bit, reset 0.
  - out_peak = (out_max >= threshold) && !out_none, aligned with out_valid.
- Without the macro: neither port exists, and the logic is identical otherwise.

Test Plan:
- Single frame, SIZE=512: bin 37=1000, all others 5, band 1..511 -> out_valid exactly 10 cycles after accept; out_max=1000, out_index=37, out_none=0.
- Tie-break: bins 100 and 300 both =0xFFFF, band 0..511 -> out_index=100; swapping the two bin values gives the same result.
- Band masking: bin 0=60000, bin 200=10; first frame with band 1..511, second with band 0..0 -> first gives out_index=200, out_max=10; second gives out_index=0, out_max=60000.
- Empty band and all-zero frame: band_lo=50, band_hi=10 -> out_none=1, out_max=0; all-zero frame with full band -> out_none=1.
- Backpressure and streaming:
  - Stimulus: 20 back-to-back frames, each with a distinct peak index; out_ready low for 5 cycles midway.
  - Required: in_ready=0 exactly while out_valid && !out_ready; all 20 results in order, none lost or duplicated.
- Reset mid-stream: drop reset_n with 4 frames in flight -> out_valid=0 without waiting for a clock edge; no stale result after release. With ARGMAX_THRESHOLD_EN, threshold=1000 against peak 1000 gives out_peak=1, and against peak 999 gives out_peak=0.

Source files
------------

// File: rtl/argmax_reduction_pipe.sv
// argmax_reduction_pipe: fully pipelined band-limited argmax over a SIZE-bin frame with valid/ready backpressure.
// Define ARGMAX_THRESHOLD_EN to add the per-frame threshold input and out_peak flag.
module argmax_reduction_pipe #(
    parameter  int SIZE   = 512,
    parameter  int DATA_W = 16,
    localparam int LEVELS = $clog2(SIZE),
    localparam int IDX_W  = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_mag [SIZE],
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  band_lo,
    input  logic [IDX_W-1:0]  band_hi,
`ifdef ARGMAX_THRESHOLD_EN
    input  logic [DATA_W-1:0] threshold,
    output logic              out_peak,
`endif
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_none,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int NODES = 2*SIZE - 1;

    logic              en;
    logic [SIZE-1:0]   band_m;
    logic [LEVELS:0]   v_q, v_d;
    logic [DATA_W-1:0] mag_d [NODES];
    logic [IDX_W-1:0]  idx_d [NODES];
    logic [DATA_W-1:0] mag_q [NODES];
    logic [IDX_W-1:0]  idx_q [NODES];
    logic [DATA_W-1:0] fin_mag;
    logic [IDX_W-1:0]  fin_idx;
    logic              out_valid_q, out_none_q;
    logic [DATA_W-1:0] out_max_q;
    logic [IDX_W-1:0]  out_index_q;

    assign en       = !(out_valid_q && !out_ready);
    assign in_ready = en;
    assign v_d      = {v_q[LEVELS-1:0], in_valid};
    // Low mask keeps k >= band_lo, high mask keeps k <= band_hi; an inverted band leaves no overlap.
    assign band_m   = ({SIZE{1'b1}} << band_lo) & ({SIZE{1'b1}} >> ~band_hi);

    // All tree levels share one node array: level s starts at 2*SIZE - (2*SIZE >> s).
    for (genvar s = 0; s <= LEVELS; s++) begin : g_lvl
        localparam int B = 2*SIZE - ((2*SIZE) >> s);
        localparam int P = 2*SIZE - ((4*SIZE) >> s);
        if (s == 0) begin : g_cap
            for (genvar k = 0; k < SIZE; k++) begin : g_bin
                assign mag_d[k] = band_m[k] ? in_mag[k] : '0;
                assign idx_d[k] = IDX_W'(k);
            end
        end else begin : g_cmp
            for (genvar k = 0; k < (SIZE >> s); k++) begin : g_pair
                logic take_r;
                // The left operand always covers the lower bins, so it wins ties.
                assign take_r       = mag_q[P+2*k+1] > mag_q[P+2*k];
                assign mag_d[B + k] = take_r ? mag_q[P+2*k+1] : mag_q[P+2*k];
                assign idx_d[B + k] = take_r ? idx_q[P+2*k+1] : idx_q[P+2*k];
            end
        end
    end

    always_ff @(posedge clk)
        if (en) begin
            mag_q <= mag_d;
            idx_q <= idx_d;
        end

    assign fin_mag = mag_q[NODES-1];
    assign fin_idx = idx_q[NODES-1];

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_index_q <= '0;
            out_none_q  <= 1'b0;
        end else if (en) begin
            v_q         <= v_d;
            out_valid_q <= v_q[LEVELS];
            out_max_q   <= fin_mag;
            out_index_q <= fin_idx;
            out_none_q  <= fin_mag == '0;
        end

    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_index = out_index_q;
    assign out_none  = out_none_q;

`ifdef ARGMAX_THRESHOLD_EN
    logic [DATA_W-1:0] thr_q [LEVELS+1];
    logic              out_peak_q;

    always_ff @(posedge clk)
        if (en) begin
            thr_q[0] <= threshold;
            for (int i = 1; i <= LEVELS; i++) thr_q[i] <= thr_q[i-1];
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) out_peak_q <= 1'b0;
        else if (en)  out_peak_q <= (fin_mag >= thr_q[LEVELS]) && (fin_mag != '0);

    assign out_peak = out_peak_q;
`endif
endmodule

// File: tb/tb_argmax_reduction_pipe.sv
// tb_argmax_reduction_pipe: table-driven and hand-sequenced checks of argmax_reduction_pipe at SIZE=512.
module tb_argmax_reduction_pipe;
    localparam int SIZE = 512;

    typedef struct {
        int          b0;
        logic [15:0] v0;
        int          b1;
        logic [15:0] v1;
        logic [15:0] fill;
        logic [8:0]  lo;
        logic [8:0]  hi;
        logic [15:0] e_max;
        logic [8:0]  e_idx;
        logic        e_none;
    } vec_t;

    typedef struct {
        logic [15:0] mx;
        logic [8:0]  ix;
        logic        nn;
        logic        pk;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_mag [SIZE];
    logic        in_valid, in_ready, out_none, out_valid, out_ready;
    logic [8:0]  band_lo, band_hi, out_index;
    logic [15:0] out_max;
    logic [15:0] thr = 16'd0;
`ifdef ARGMAX_THRESHOLD_EN
    logic        out_peak;
`endif

    exp_t sb [$];
    exp_t mon_e;
    int   checks = 0, errors = 0, n_out = 0, stall_cnt = 0;

    always #5 clk = ~clk;

    argmax_reduction_pipe #(.SIZE(SIZE), .DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_mag(in_mag), .in_valid(in_valid), .in_ready(in_ready),
        .band_lo(band_lo), .band_hi(band_hi),
`ifdef ARGMAX_THRESHOLD_EN
        .threshold(thr), .out_peak(out_peak),
`endif
        .out_max(out_max), .out_index(out_index), .out_none(out_none),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int b0, int v0, int b1, int v1, int fill, int lo, int hi,
                                int em, int ei, int en);
        vec_t v;
        v.b0 = b0; v.v0 = 16'(v0); v.b1 = b1; v.v1 = 16'(v1); v.fill = 16'(fill);
        v.lo = 9'(lo); v.hi = 9'(hi); v.e_max = 16'(em); v.e_idx = 9'(ei); v.e_none = en[0];
        return v;
    endfunction

    task automatic set_frame(input vec_t v);
        for (int i = 0; i < SIZE; i++) in_mag[i] = v.fill;
        if (v.b0 >= 0) in_mag[v.b0] = v.v0;
        if (v.b1 >= 0) in_mag[v.b1] = v.v1;
        band_lo = v.lo;
        band_hi = v.hi;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.mx = v.e_max; e.ix = v.e_idx; e.nn = v.e_none;
        e.pk = (v.e_max >= thr) && !v.e_none;
        sb.push_back(e);
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v);
        set_frame(v);
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(v);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed 0, want 1");
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
        check(name, sb.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (!in_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got index %0d max %0d, want no output", out_index, out_max);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_max", out_max, mon_e.mx);
                    check("out_none", out_none, mon_e.nn);
                    if (!mon_e.nn) check("out_index", out_index, mon_e.ix);
`ifdef ARGMAX_THRESHOLD_EN
                    check("out_peak", out_peak, mon_e.pk);
`endif
                    n_out++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [14];
        int   n, base, stale;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        band_lo   = '0;
        band_hi   = '0;
        for (int i = 0; i < SIZE; i++) in_mag[i] = '0;
        tbl[0]  = mk(37, 1000, -1, 0, 5, 1, 511, 1000, 37, 0);
        tbl[1]  = mk(100, 'hFFFF, 300, 'hFFFF, 0, 0, 511, 'hFFFF, 100, 0);
        tbl[2]  = mk(256, 'hFFFF, 255, 'hFFFF, 16, 0, 511, 'hFFFF, 255, 0);
        tbl[3]  = mk(-1, 0, -1, 0, 40, 2, 9, 40, 2, 0);
        tbl[4]  = mk(0, 60000, 200, 10, 0, 1, 511, 10, 200, 0);
        tbl[5]  = mk(0, 60000, 200, 10, 0, 0, 0, 60000, 0, 0);
        tbl[6]  = mk(20, 500, -1, 0, 9, 50, 10, 0, 0, 1);
        tbl[7]  = mk(-1, 0, -1, 0, 0, 0, 511, 0, 0, 1);
        tbl[8]  = mk(511, 3, -1, 0, 100, 511, 511, 3, 511, 0);
        tbl[9]  = mk(77, 0, -1, 0, 100, 77, 77, 0, 77, 1);
        tbl[10] = mk(10, 900, 400, 50, 1, 20, 450, 50, 400, 0);
        tbl[11] = mk(20, 700, 451, 800, 1, 20, 450, 700, 20, 0);
        tbl[12] = mk(511, 'hFFFF, -1, 0, 'hFFFE, 0, 511, 'hFFFF, 511, 0);
        tbl[13] = mk(19, 800, 451, 900, 1, 20, 450, 1, 20, 0);

        // Reset values, then accept on the very first edge after release.
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_max", out_max, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_none", out_none, 0);
        check("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        set_frame(tbl[0]);
        in_valid = 1'b1;
        push_exp(tbl[0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) break;
        end
        check("latency", n, 10);
        wait_drain("drain_latency");

        // Whole table back-to-back.
        base = n_out;
        foreach (tbl[i]) send(tbl[i]);
        wait_drain("drain_table");
        check("table_count", n_out - base, 14);

        // 20 streamed frames with a 5-cycle output stall midway.
        base = n_out;
        stall_cnt = 0;
        fork
            for (int i = 0; i < 20; i++)
                send(mk(i*25 + 7, 1000 + 3*i, -1, 0, 2, 0, 511, 1000 + 3*i, i*25 + 7, 0));
            begin
                repeat (15) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("drain_stream");
        check("stream_count", n_out - base, 20);
        check("stall_seen", stall_cnt > 0, 1);

        // Threshold boundary: peak equal to threshold and one below.
        thr = 16'd1000;
        send(mk(5, 1000, -1, 0, 3, 0, 511, 1000, 5, 0));
        send(mk(6, 999, -1, 0, 3, 0, 511, 999, 6, 0));
        wait_drain("drain_thr");
        thr = 16'd0;

        // Asynchronous flush with four frames in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(tbl[i]);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        #2 reset_n = 1'b0;
        #1 check("async_flush", out_valid, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale", stale, 0);
        @(posedge clk); #1;
        base = n_out;
        send(tbl[4]);
        wait_drain("drain_post_rst");
        check("post_rst_count", n_out - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
